// File: rtl/adc_frame_buffer_if.sv
// Frame handshake and random-access read port between adc_frame_buffer (slave)
// and the downstream frame consumer (master).
interface adc_frame_buffer_if #(
  parameter int N_ADC  = 2,
  parameter int N_CH   = 4,
  parameter int DATA_W = 22,
  parameter int DEPTH  = 512
);
  localparam int CH_W  = $clog2(N_ADC*N_CH);
  localparam int IDX_W = $clog2(DEPTH);

  logic                     frame_ready;
  logic                     frame_ack;
  logic [CH_W-1:0]          rd_ch;
  logic [IDX_W-1:0]         rd_idx;
  logic signed [DATA_W-1:0] rd_data;

  modport master (input frame_ready, rd_data, output frame_ack, rd_ch, rd_idx);
  modport slave  (output frame_ready, rd_data, input frame_ack, rd_ch, rd_idx);
endinterface

// File: rtl/adc_frame_buffer.sv
// ADC sample-vector capture into DEPTH-sample frames with ready/ack hand-off.
// Define ADC_FRAME_PINGPONG_EN for two banks; default build is a single bank.
module adc_frame_buffer #(
  parameter int N_ADC  = 2,
  parameter int N_CH   = 4,
  parameter int WORD_W = 32,
  parameter int DATA_W = 22,
  parameter int DEPTH  = 512
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          CASCOUT,
  input  logic [N_ADC*N_CH*WORD_W-1:0]  adc_data,
  adc_frame_buffer_if.slave             bus,
  output logic                          overrun,
  output logic [15:0]                   frame_count
);
  localparam int NCH   = N_ADC*N_CH;
  localparam int CH_W  = $clog2(NCH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int ST_W  = WORD_W - DATA_W;
`ifdef ADC_FRAME_PINGPONG_EN
  localparam int   NB     = 2;
  localparam logic TOGGLE = 1'b1;
`else
  localparam int   NB     = 1;
  localparam logic TOGGLE = 1'b0;
`endif
  localparam int AW = $clog2(NB*DEPTH);

  // CASCOUT is asynchronous: two sync flops then an edge register
  logic [1:0] r_sync;
  logic       r_edge;
  logic       w_cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], CASCOUT};
      r_edge <= r_sync[1];
    end
  end

  assign w_cap = r_sync[1] & ~r_edge;

  // Keep the top DATA_W bits of each word; the status bits are dropped
  logic [NCH-1:0][DATA_W-1:0] w_vec;
  logic [NCH-1:0]             w_status_unused;

  for (genvar k = 0; k < NCH; k++) begin : g_field
    assign w_vec[k]           = adc_data[k*WORD_W + WORD_W-1 -: DATA_W];
    assign w_status_unused[k] = ^adc_data[k*WORD_W +: ST_W];
  end

  logic [1:0]       r_bank_full;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic             r_overrun;
  logic [15:0]      r_frame_count;
  logic             w_ack;
  logic             w_wr_en;
  logic             w_last;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_rd_addr;

  always_comb begin
    w_ack     = bus.frame_ack & r_bank_full[r_rd_bank];
    w_wr_en   = w_cap & ~r_bank_full[r_wr_bank] & ~rst;
    w_last    = (r_wr_idx == IDX_W'(DEPTH-1));
    w_wr_addr = AW'({r_wr_bank, r_wr_idx});
    w_rd_addr = AW'({r_rd_bank, bus.rd_idx});
  end

  // Completion always targets an empty bank and ack a full one, so the two
  // bank_full updates below never collide on the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_full   <= 2'b00;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_idx      <= '0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_ack) begin
        r_bank_full[r_rd_bank] <= 1'b0;
        r_rd_bank              <= r_rd_bank ^ TOGGLE;
      end
      if (w_cap) begin
        if (r_bank_full[r_wr_bank]) begin
          r_overrun <= 1'b1;
        end else if (w_last) begin
          r_bank_full[r_wr_bank] <= 1'b1;
          r_wr_idx               <= '0;
          r_wr_bank              <= r_wr_bank ^ TOGGLE;
          r_frame_count          <= r_frame_count + 16'd1;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
    end
  end

  // Sample memory is never cleared; only flags and pointers reset
  logic [NCH-1:0][DATA_W-1:0] r_mem [NB*DEPTH];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_vec;
  end

  logic [NCH-1:0][DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0]          w_rd_sample;
  logic signed [DATA_W-1:0]   r_rd_data;

  always_comb begin
    w_rd_word   = r_mem[w_rd_addr];
    w_rd_sample = '0;
    for (int c = 0; c < NCH; c++)
      if (bus.rd_ch == CH_W'(c)) w_rd_sample = w_rd_word[c];
  end

  always_ff @(posedge clk) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= w_rd_sample;
  end

  assign bus.rd_data     = r_rd_data;
  assign bus.frame_ready = r_bank_full[r_rd_bank];
  assign overrun         = r_overrun;
  assign frame_count     = r_frame_count;
endmodule

// File: tb/tb_adc_frame_buffer.sv
// Directed bench for adc_frame_buffer: table-driven frame reads plus hand-written
// ready/ack, overrun and reset sequences for both bank configurations.
module tb_adc_frame_buffer;
  localparam int N_ADC  = 2;
  localparam int N_CH   = 4;
  localparam int WORD_W = 32;
  localparam int DATA_W = 22;
  localparam int DEPTH  = 512;
  localparam int NCH    = N_ADC*N_CH;
  localparam int CH_W   = $clog2(NCH);
  localparam int IDX_W  = $clog2(DEPTH);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   CASCOUT;
  logic [NCH*WORD_W-1:0]  adc_data;
  logic                   overrun;
  logic [15:0]            frame_count;

  adc_frame_buffer_if #(.N_ADC(N_ADC), .N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  adc_frame_buffer #(
    .N_ADC(N_ADC), .N_CH(N_CH), .WORD_W(WORD_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .CASCOUT(CASCOUT), .adc_data(adc_data),
    .bus(bus), .overrun(overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    ch;
    int    idx;
    int    exp;
  } rd_vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Sample n carries value n*16+k on word k; vector 10 carries sign-extension probes
  function automatic logic [NCH*WORD_W-1:0] mkvec(input int n);
    logic [NCH*WORD_W-1:0] v;
    logic [31:0] sp [4];
    sp[0] = 32'hFFFFFC00;
    sp[1] = 32'h80000000;
    sp[2] = 32'h000007FF;
    sp[3] = 32'h7FFFFC00;
    for (int k = 0; k < NCH; k++) begin
      v[k*WORD_W +: WORD_W] = {22'(n*16+k), 10'h3FF};
      if (n == 10 && k < 4) v[k*WORD_W +: WORD_W] = sp[k];
    end
    return v;
  endfunction

  task automatic strobe(input int n);
    @(negedge clk);
    adc_data = mkvec(n);
    CASCOUT  = 1'b1;
    repeat (3) @(negedge clk);
    CASCOUT  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic strobes(input int n0, input int cnt);
    for (int i = 0; i < cnt; i++) strobe(n0 + i);
  endtask

  // Last sample of an empty-buffer frame: ready must appear exactly after the cap edge
  task automatic strobe_last(input int n);
    @(negedge clk);
    adc_data = mkvec(n);
    CASCOUT  = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("ready_before_cap", bus.frame_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_cap", bus.frame_ready, 1);
    @(negedge clk);
    CASCOUT = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic rd(input int ch, input int idx, output logic signed [31:0] v);
    @(negedge clk);
    bus.rd_ch  = CH_W'(ch);
    bus.rd_idx = IDX_W'(idx);
    @(posedge clk);
    #1 v = bus.rd_data;
  endtask

  task automatic ack();
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"},   bus.frame_ready, 0);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_count"},   frame_count, 0);
  endtask

  rd_vec_t tbl [9];
  logic signed [31:0] v;

  initial begin
    tbl[0] = '{"rd_ch5_idx3",   5,   3, 53};
    tbl[1] = '{"rd_ch0_idx0",   0,   0, 0};
    tbl[2] = '{"rd_ch7_idx511", 7, 511, 8183};
    tbl[3] = '{"rd_ch3_idx256", 3, 256, 4099};
    tbl[4] = '{"sign_m1",       0,  10, -1};
    tbl[5] = '{"sign_min",      1,  10, -2097152};
    tbl[6] = '{"status_drop",   2,  10, 1};
    tbl[7] = '{"sign_max",      3,  10, 2097151};
    tbl[8] = '{"rd_ch4_idx10",  4,  10, 164};

    rst = 1'b1; CASCOUT = 1'b0; adc_data = '0;
    bus.frame_ack = 1'b0; bus.rd_ch = '0; bus.rd_idx = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    rst = 1'b0;

    // Partial frame then reset: the next frame must start at index 0
    strobes(5000, 100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("midrst");
    rst = 1'b0;

    strobes(0, DEPTH-1);
    strobe_last(DEPTH-1);
    chk("f0_count", frame_count, 1);
    chk("f0_overrun", overrun, 0);
    for (int i = 0; i < 9; i++) begin
      rd(tbl[i].ch, tbl[i].idx, v);
      chk(tbl[i].nm, v, tbl[i].exp);
    end

`ifdef ADC_FRAME_PINGPONG_EN
    // Frame 1: ack lands in the same cycle as its final cap
    strobes(512, DEPTH-1);
    chk("f1_pre_count", frame_count, 1);
    @(negedge clk);
    adc_data = mkvec(1023);
    CASCOUT  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("same_cyc_ready", bus.frame_ready, 1);
    chk("same_cyc_count", frame_count, 2);
    @(negedge clk);
    bus.frame_ack = 1'b0;
    CASCOUT = 1'b0;
    repeat (3) @(negedge clk);
    rd(5, 3, v);
    chk("same_cyc_rd_bank1", v, 8245);
    chk("same_cyc_overrun", overrun, 0);

    // Frame 2 into the freed bank, then one more strobe with both banks full
    strobes(1024, DEPTH);
    chk("f2_count", frame_count, 3);
    chk("f2_ready", bus.frame_ready, 1);
    chk("f2_no_overrun", overrun, 0);
    strobe(1536);
    chk("both_full_overrun", overrun, 1);
    chk("both_full_count", frame_count, 3);
    rd(5, 3, v);
    chk("both_full_rd_f1", v, 8245);
    ack();
    chk("ack1_ready", bus.frame_ready, 1);
    rd(5, 3, v);
    chk("ack1_rd_f2", v, 16437);
    rd(0, 0, v);
    chk("ack1_rd_f2_idx0", v, 16384);
    ack();
    chk("ack2_ready", bus.frame_ready, 0);
    chk("ack2_overrun_sticky", overrun, 1);
`else
    // Single bank: strobes beyond the frame are dropped until ack
    strobes(600, 8);
    chk("sb_count", frame_count, 1);
    chk("sb_overrun", overrun, 1);
    chk("sb_ready", bus.frame_ready, 1);
    rd(0, 0, v);
    chk("sb_keep_idx0", v, 0);
    rd(5, 3, v);
    chk("sb_keep_idx3", v, 53);
    ack();
    chk("sb_ack_ready", bus.frame_ready, 0);
    ack();
    chk("sb_ack_idle_ready", bus.frame_ready, 0);
    strobes(2000, DEPTH-1);
    strobe_last(2511);
    chk("sb_f1_count", frame_count, 2);
    chk("sb_f1_overrun", overrun, 1);
    rd(2, 0, v);
    chk("sb_f1_idx0", v, 32002);
    rd(2, 511, v);
    chk("sb_f1_idx511", v, 40178);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adc_frame_buffer.md
# adc_frame_buffer

Parametrised, clocked successor to the ADC accumulation stage. Captures one multi-channel sample vector from `N_ADC` ADCs on each rising edge of the ADC cascade strobe and strips the status bits. Stores samples into `DEPTH`-sample frames in a double-buffered (ping-pong) memory and hands complete frames to the downstream separation logic through a ready/ack handshake and a registered random-access read port. Sits between the ADC collection logic and the matrix-processing blocks.

## Interface

Parameters:
- `N_ADC`, 2, number of ADC devices
- `N_CH`, 4, channels per ADC
- `WORD_W`, 32, raw ADC word width
- `DATA_W`, 22, sample field width; field is `word[WORD_W-1 -: DATA_W]`, low `WORD_W-DATA_W` bits are status and discarded
- `DEPTH`, 512, samples per frame (power of two, ≥4)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `CASCOUT`  in  1  asynchronous ADC cascade strobe; rising edge = new sample vector valid
- `adc_data`  in  `N_ADC*N_CH*WORD_W`  raw words; word k at `[k*WORD_W +: WORD_W]`, k = adc*N_CH + ch
- `frame_ready`  out  1  a complete frame is readable
- `frame_ack`  in  1  single-cycle pulse: consumer has finished with the readable frame
- `rd_ch`  in  `$clog2(N_ADC*N_CH)`  read channel index
- `rd_idx`  in  `$clog2(DEPTH)`  read sample index (0 = oldest)
- `rd_data`  out  `DATA_W` signed  sample at (`rd_ch`, `rd_idx`) of readable frame
- `overrun`  out  1  sticky: sample vector dropped because no bank was free
- `frame_count`  out  16  completed frames, wraps at 2^16

## Operation

- `CASCOUT` passes through a 2-flop synchroniser then a rising-edge detector; resulting single-cycle `cap` pulse samples `adc_data` on that cycle.
- Each word reduced to its `DATA_W` field, interpreted as two's complement (arithmetic, not logical, shift).
- All `N_ADC*N_CH` samples of one vector written in the `cap` cycle to address `wr_idx` of bank `wr_bank`.
- Index order ascending: first sample of a frame at index 0, last at `DEPTH-1`.
- Per-bank flag `bank_full[1:0]`; write-side state `wr_bank`, `wr_idx`; read-side pointer `rd_bank`.
- On `cap`:
  - if `bank_full[wr_bank]`: vector dropped, `overrun` set, `wr_idx` unchanged;
  - else: write; if `wr_idx == DEPTH-1`, then `bank_full[wr_bank]`←1, `wr_idx`←0, `wr_bank` toggles, `frame_count`++; otherwise `wr_idx`++.
- `frame_ready = bank_full[rd_bank]`.
- `frame_ack` while `frame_ready`: `bank_full[rd_bank]`←0, `rd_bank` toggles. `frame_ack` while not `frame_ready` is ignored.
- Frame completion and `frame_ack` in the same cycle both take effect. Bank freed by ack is available to the next `cap`, not the same one.
- `overrun` cleared only by `rst`.
- `rst` mid-frame discards the partial frame. Memory contents are not cleared, only flags and pointers.

## Timing

- Reset values: `frame_ready`=0, `rd_data`=0, `overrun`=0, `frame_count`=0; `wr_bank`=`rd_bank`=0, `wr_idx`=0, `bank_full`=00, synchroniser and edge flops 0.
- `CASCOUT` rise to `cap`: 3 `clk` cycles (2 sync + 1 edge register). `adc_data` must be stable from the `CASCOUT` edge through the `cap` cycle.
- `CASCOUT` high and low each must last ≥2 `clk` periods.
- Last-sample `cap` to `frame_ready`=1: 1 cycle (visible the cycle after `cap`).
- `frame_ack` to `frame_ready` update: 1 cycle.
- Read latency: `rd_data` registered, valid 1 cycle after `rd_ch`/`rd_idx`/`rd_bank`. Reads with `frame_ready`=0 return stale data; no error is flagged.
- `rd_ch` ≥ `N_ADC*N_CH` returns 0.

## Configuration

- `ADC_FRAME_PINGPONG_EN` defined: two banks as described. Capture continues while the consumer holds one frame.
- Not defined: single bank.
  - `wr_bank` and `rd_bank` fixed at 0.
  - Every `cap` while `bank_full[0]` is dropped and sets `overrun`.
  - Capture resumes at index 0 on the `cap` after `frame_ack`.
  - Memory halves; ports unchanged.

## Test plan

- Reset, then 512 strobes with word k = `{22'(n*16+k), 10'h3FF}` for sample n → `frame_ready` rises 1 cycle after 512th `cap`; `rd_data(ch=5, idx=3)` = 53; `frame_count`=1; `overrun`=0.
- Word `32'hFFFFFC00` → `rd_data` = −1 (22'h3FFFFF sign-extended); word `32'h80000000` → −2097152.
- Ping-pong: fill frame 0, no ack, fill frame 1, issue one more strobe → `overrun`=1, both banks full. Then ack → `frame_ready` stays 1 and reads return frame 1 data; a second ack drops `frame_ready`.
- `frame_ack` in the same cycle as frame-1 completion → `frame_ready` remains 1, `rd_bank`=1, `frame_count`=2.
- `rst` asserted after 100 samples → outputs at reset values; next 512 strobes produce a frame whose index 0 is the first post-reset sample.
- Without `ADC_FRAME_PINGPONG_EN`: 520 strobes without ack → `frame_count`=1, `overrun`=1. After ack, the next strobe is written at index 0.
